// File: rtl/differential_in_conditioner.sv
// differential_in_conditioner: per-channel synchroniser, glitch filter, edge pulses and idle timeout
module differential_in_conditioner #(
  parameter int DIFF_BUFFER_WIDTH = 1,
  parameter int FILTER_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIFF_BUFFER_WIDTH-1:0] d_in,
  output logic [DIFF_BUFFER_WIDTH-1:0] d_out,
  output logic [DIFF_BUFFER_WIDTH-1:0] rise,
  output logic [DIFF_BUFFER_WIDTH-1:0] fall,
  output logic [DIFF_BUFFER_WIDTH-1:0] idle
);
  localparam int FW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [IW-1:0] T_MAX  = IW'(TIMEOUT_CYCLES);
  for (genvar i = 0; i < DIFF_BUFFER_WIDTH; i++) begin : g_ch
    (* ASYNC_REG = "TRUE" *) logic s0_q;
    (* ASYNC_REG = "TRUE" *) logic s1_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic          out_q, rise_q, fall_q, idle_q;
    logic          out_d, rise_d, fall_d, idle_d;
    logic          accept;
    always_comb begin
      accept = (s1_q != out_q) && (fcnt_q == F_LAST);
      fcnt_d = (s1_q == out_q || accept) ? '0 : fcnt_q + FW'(1);
      out_d  = accept ? s1_q : out_q;
      rise_d = accept & s1_q;
      fall_d = accept & ~s1_q;
      icnt_d = accept ? '0 : (icnt_q != T_MAX) ? icnt_q + IW'(1) : icnt_q;
      idle_d = accept ? 1'b0 : (icnt_q != T_MAX) ? (icnt_q + IW'(1) == T_MAX) : idle_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        s0_q   <= 1'b0;
        s1_q   <= 1'b0;
        fcnt_q <= '0;
        icnt_q <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        idle_q <= 1'b0;
      end else begin
        s0_q   <= d_in[i];
        s1_q   <= s0_q;
        fcnt_q <= fcnt_d;
        icnt_q <= icnt_d;
        out_q  <= out_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        idle_q <= idle_d;
      end
    end
    assign d_out[i] = out_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign idle[i]  = idle_q;
  end
endmodule

// File: tb/tb_differential_in_conditioner.sv
// tb_differential_in_conditioner: directed checks of filter latency, glitch rejection, idle and reset
module tb_differential_in_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d_in = 4'h0;
  logic [3:0] d_out, rise, fall, idle;
  int checks = 0;
  int errors = 0;
  differential_in_conditioner #(
    .DIFF_BUFFER_WIDTH(4),
    .FILTER_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .d_in(d_in),
    .d_out(d_out),
    .rise(rise),
    .fall(fall),
    .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] i);
    chk({tag, ".d_out"}, d_out, o);
    chk({tag, ".rise"}, rise, r);
    chk({tag, ".fall"}, fall, f);
    chk({tag, ".idle"}, idle, i);
  endtask
  initial begin
    for (int k = 0; k < 5; k++) begin
      d_in = 4'($urandom_range(15));
      step(1);
      chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst  = 1'b0;
    d_in = 4'h0;
    step(1);
    chk_all("post_reset", 4'h0, 4'h0, 4'h0, 4'h0);
    step(14);
    chk("idle_n15", idle, 4'h0);
    step(1);
    chk("idle_n16", idle, 4'hf);
    step(3);
    chk("idle_hold", idle, 4'hf);
    d_in = 4'b0100;
    step(5);
    chk_all("rise_e4", 4'h0, 4'h0, 4'h0, 4'hf);
    step(1);
    chk_all("rise_e5", 4'b0100, 4'b0100, 4'h0, 4'b1011);
    step(1);
    chk_all("rise_e6", 4'b0100, 4'h0, 4'h0, 4'b1011);
    step(14);
    chk("idle_t15", idle, 4'b1011);
    step(1);
    chk("idle_t16", idle, 4'hf);
    d_in = 4'h0;
    step(5);
    chk_all("fall_e4", 4'b0100, 4'h0, 4'h0, 4'hf);
    step(1);
    chk_all("fall_e5", 4'h0, 4'h0, 4'b0100, 4'b1011);
    step(1);
    chk("fall_e6", fall, 4'h0);
    d_in = 4'b0001;
    step(3);
    d_in = 4'h0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("glitch3.d_out", d_out, 4'h0);
      chk("glitch3.rise", rise, 4'h0);
    end
    d_in = 4'b0001;
    step(4);
    d_in = 4'h0;
    step(1);
    chk("pulse4_e4.rise", rise, 4'h0);
    step(1);
    chk("pulse4_e5.rise", rise, 4'b0001);
    chk("pulse4_e5.d_out", d_out, 4'b0001);
    chk("pulse4_e5.idle0", idle & 4'b0001, 4'h0);
    step(3);
    chk("pulse4_e8.fall", fall, 4'h0);
    chk("pulse4_e8.d_out", d_out, 4'b0001);
    step(1);
    chk_all("pulse4_e9", 4'h0, 4'h0, 4'b0001, idle & 4'b1110);
    chk("pulse4_e9.idle0", idle & 4'b0001, 4'h0);
    d_in = 4'hf;
    step(4);
    rst = 1'b1;
    step(1);
    chk_all("rst_e4", 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    step(1);
    chk_all("rst_e5", 4'h0, 4'h0, 4'h0, 4'h0);
    step(4);
    chk("rst_e9.d_out", d_out, 4'h0);
    step(1);
    chk_all("rst_e10", 4'hf, 4'hf, 4'h0, 4'h0);
    step(1);
    chk("rst_e11.rise", rise, 4'h0);
    step(14);
    chk("idle_r15", idle, 4'h0);
    step(1);
    chk("idle_r16", idle, 4'hf);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/differential_in_conditioner.md
# differential_in_conditioner

Per-channel conditioning stage placed directly after the differential input buffer, consuming its single-ended `d_out` bus. For each bit it synchronises the asynchronous input into the fabric clock domain and rejects glitches shorter than a programmed number of cycles. It then emits the filtered level, single-cycle rise and fall pulses, and an inactivity flag. Downstream logic (trigger, handshake and serial-receive blocks) uses only these conditioned signals, never raw pad inputs.

## Interface
- `DIFF_BUFFER_WIDTH`, default 1: number of independent channels; must match the upstream buffer width.
- `FILTER_CYCLES`, default 4: consecutive synchronised samples required to accept a level change; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1024: cycles without a filtered transition before `idle` asserts; legal range ≥2.

- `clk`  in  1  fabric clock; all logic is clocked on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `d_in`  in  DIFF_BUFFER_WIDTH  asynchronous single-ended inputs from the differential buffer outputs.
- `d_out`  out  DIFF_BUFFER_WIDTH  filtered, synchronised level.
- `rise`  out  DIFF_BUFFER_WIDTH  one-cycle pulse when `d_out` goes 0→1.
- `fall`  out  DIFF_BUFFER_WIDTH  one-cycle pulse when `d_out` goes 1→0.
- `idle`  out  DIFF_BUFFER_WIDTH  high while the channel has seen no filtered transition for ≥TIMEOUT_CYCLES.

## Operation
- All channels are identical and fully independent. No state is shared between channels.
- Synchroniser: two flops, `s0 <= d_in[i]` and `s1 <= s0`. Only `s1` feeds the filter. Both flops carry the ASYNC_REG attribute.
- Filter counter `fcnt`, width clog2(FILTER_CYCLES) (minimum 1 bit), evaluated every edge:
  - `s1 == d_out`: `fcnt <= 0`.
  - `s1 != d_out` and `fcnt == FILTER_CYCLES-1`: `d_out <= s1` and `fcnt <= 0`.
  - Otherwise: `fcnt <= fcnt+1`.
- Consequences of the filter rule:
  - Any excursion of `s1` lasting fewer than FILTER_CYCLES cycles is discarded completely, and `d_out` does not move.
  - An excursion of exactly FILTER_CYCLES cycles is accepted.
  - With FILTER_CYCLES=1, the filter reduces to a single flop.
- Edge outputs:
  - `rise` and `fall` are registered.
  - They are asserted in exactly the cycle in which the new `d_out` value first appears, for one cycle only.
  - `rise` and `fall` are never high together on the same channel.
- Idle counter `icnt`, width clog2(TIMEOUT_CYCLES+1), evaluated every edge:
  - On an edge that changes `d_out`: `icnt <= 0` and `idle <= 0`.
  - Else if `icnt != TIMEOUT_CYCLES`: `icnt <= icnt+1` and `idle <= (icnt+1 == TIMEOUT_CYCLES)`.
  - Else: hold. The counter saturates and does not wrap.
- Reset (`rst` high at an edge):
  - All of `s0`, `s1`, `fcnt`, `icnt`, `d_out`, `rise`, `fall` and `idle` become 0.
  - Reset overrides every other condition, including a filter acceptance on that same edge.
  - Reset asserted mid-filter or mid-timeout discards all progress.
  - After release, a held-high input is re-qualified from scratch and produces a fresh `rise`.

## Timing
- Reset values: `d_out`=0, `rise`=0, `fall`=0, `idle`=0 on every channel.
- Latency: `d_in` changes and is stable before edge E0.
  - `s0` updates at E0 and `s1` at E1.
  - `d_out`, `rise` or `fall` update at edge E(FILTER_CYCLES+1).
  - Default parameters: the change is visible after the 5th edge following capture.
- Glitch rejection: a `d_in` pulse that covers fewer than FILTER_CYCLES sampling edges produces no output activity.
- Idle:
  - After reset release, the first non-reset edge is N1. `idle` rises after edge N(TIMEOUT_CYCLES).
  - After a `d_out` transition at edge T, `idle` rises after edge T+TIMEOUT_CYCLES.
  - `idle` falls on the same edge that changes `d_out`, coincident with `rise`/`fall`.
- Throughput: a channel can toggle at most once every FILTER_CYCLES cycles. Inputs alternating faster than this are held at the last accepted level.

## Test plan
- Reset with `d_in` toggling randomly, `rst` held 5 cycles → all outputs 0 throughout and on the first post-reset cycle.
- FILTER_CYCLES=4: 0→1 step captured at E0 → `d_out`=1 and `rise`=1 after E5. `rise` returns to 0 after E6. A later 1→0 step gives `fall` with the same 5-edge latency.
- FILTER_CYCLES=4: high pulse of 3 cycles → no `d_out` or `rise` activity. High pulse of 4 cycles → `rise` followed by `fall` exactly 4 cycles later.
- TIMEOUT_CYCLES=16, input static after reset → `idle` rises after the 16th edge post-reset and stays high. A filtered transition clears `idle` in the same cycle as `rise`.
- DIFF_BUFFER_WIDTH=4: step only on bit 2 → only `rise[2]`. Bits 0, 1 and 3 stay quiet, and their `idle` asserts on schedule.
- `rst` pulsed one edge before a filter acceptance, with input held high → no `rise` at the expected edge. A new `rise` follows 5 edges after reset release.
